// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if
//   Bundles the PS/2 pin inputs and the scan-code outputs of ps2_kbd_rx.
//
//   Signals:
//     ps2_clk_i   raw PS/2 clock pin (asynchronous)
//     ps2_data_i  raw PS/2 data pin (asynchronous)
//     code_o      last valid scan code, held until the next valid frame
//     strobe_o    one-cycle pulse: code_o just updated
//     err_o       one-cycle pulse: frame rejected
//     busy_o      high while a frame is in progress
//     state_dbg   current receiver FSM state, for debug/checkers
//
//   Handshake: strobe_o is a valid-only pulse with no ready. The consumer
//   must take code_o in the cycle strobe_o is high; code_o stays stable
//   afterwards until the next strobe_o or a reset. err_o is an
//   informational pulse and is never high together with strobe_o.
//
//   Modports:
//     master  the receiver (drives the outputs, reads the pins)
//     slave   the keyboard-side consumer / pin driver
interface ps2_kbd_rx_if;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic [7:0] code_o;
    logic       strobe_o;
    logic       err_o;
    logic       busy_o;
    logic [1:0] state_dbg;

    modport master (
        input  ps2_clk_i,
        input  ps2_data_i,
        output code_o,
        output strobe_o,
        output err_o,
        output busy_o,
        output state_dbg
    );

    modport slave (
        output ps2_clk_i,
        output ps2_data_i,
        input  code_o,
        input  strobe_o,
        input  err_o,
        input  busy_o,
        input  state_dbg
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx
//   PS/2 keyboard receiver (device-to-host only). Synchronizes and
//   deglitches the raw PS/2 clock/data pins, shifts in 11-bit frames
//   (start, 8 data LSB first, odd parity, stop) and reports each frame as
//   either a scan code with strobe_o or a one-cycle err_o.
//
//   Ports:
//     clk      system clock, all logic on the rising edge
//     reset_i  synchronous reset, active-low
//     bus      ps2_kbd_rx_if.master (pins in, code/strobe/err/busy out)
//
//   Parameters:
//     FILTER_LEN      identical synchronized samples needed before a
//                     filtered line changes level (>= 2)
//     TIMEOUT_CYCLES  clk cycles without a filtered falling clock edge
//                     mid-frame before the frame is aborted (>= 16)
module ps2_kbd_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          reset_i,
    ps2_kbd_rx_if.master  bus
);

    localparam int FCW = $clog2(FILTER_LEN);
    localparam int TCW = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input path: 2-FF synchronizers and level filters
    // ------------------------------------------------------------------
    logic           clk_s1, clk_s2, data_s1, data_s2;
    logic           clk_f, data_f;
    logic [FCW-1:0] clk_fcnt, data_fcnt;
    logic           clk_f_d;
    logic           fall_q;
    logic           data_s;

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= bus.ps2_clk_i;
            clk_s2  <= clk_s1;
            data_s1 <= bus.ps2_data_i;
            data_s2 <= data_s1;
        end
    end

    // The counter counts consecutive cycles of disagreement; the filtered
    // level flips on the cycle the count would reach FILTER_LEN, so a
    // pulse of FILTER_LEN cycles passes and anything shorter is dropped.
    always_ff @(posedge clk) begin
        if (!reset_i) begin
            clk_f    <= 1'b1;
            clk_fcnt <= '0;
        end else if (clk_s2 != clk_f) begin
            if (clk_fcnt == FCW'(FILTER_LEN - 1)) begin
                clk_f    <= clk_s2;
                clk_fcnt <= '0;
            end else begin
                clk_fcnt <= clk_fcnt + FCW'(1);
            end
        end else begin
            clk_fcnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_i) begin
            data_f    <= 1'b1;
            data_fcnt <= '0;
        end else if (data_s2 != data_f) begin
            if (data_fcnt == FCW'(FILTER_LEN - 1)) begin
                data_f    <= data_s2;
                data_fcnt <= '0;
            end else begin
                data_fcnt <= data_fcnt + FCW'(1);
            end
        end else begin
            data_fcnt <= '0;
        end
    end

    // Edge register: fall_q pulses the cycle after the filtered clock
    // drops, and data_s holds the filtered data bit seen at that moment.
    always_ff @(posedge clk) begin
        if (!reset_i) begin
            clk_f_d <= 1'b1;
            fall_q  <= 1'b0;
            data_s  <= 1'b1;
        end else begin
            clk_f_d <= clk_f;
            fall_q  <= clk_f_d & ~clk_f;
            data_s  <= data_f;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t         state, state_nx;
    logic [7:0]     shreg;
    logic [2:0]     bitcnt;
    logic           par;
    logic [TCW-1:0] tmo_cnt;
    logic           tmo_hit;
    logic           frame_ok;

    logic [7:0]     code_q, code_nx;
    logic           strobe_q, strobe_nx;
    logic           err_q, err_nx;
    logic           busy_q;

    // Timeout fires on the edge where the idle-clock counter would reach
    // TIMEOUT_CYCLES-1, i.e. TIMEOUT_CYCLES cycles after the fall_q pulse
    // that last cleared it. A simultaneous fall_q takes priority.
    assign tmo_hit  = (state != IDLE) && !fall_q
                      && (tmo_cnt == TCW'(TIMEOUT_CYCLES - 2));
    assign frame_ok = data_s && ((^shreg) ^ par);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (fall_q) begin
            case (state)
                IDLE:    if (!data_s) state_nx = DATA;
                DATA:    if (bitcnt == 3'd7) state_nx = PARITY;
                PARITY:  state_nx = STOP;
                STOP:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end else if (tmo_hit) begin
            state_nx = IDLE;
        end
    end

    // Output logic (registered below)
    always_comb begin
        strobe_nx = fall_q && (state == STOP) && frame_ok;
        err_nx    = (fall_q && (state == STOP) && !frame_ok) || tmo_hit;
        code_nx   = code_q;
        if (strobe_nx) begin
            code_nx = shreg;
        end
    end

    // Frame datapath: shift register, bit counter, parity, timeout counter
    always_ff @(posedge clk) begin
        if (!reset_i) begin
            shreg   <= '0;
            bitcnt  <= '0;
            par     <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if (fall_q) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        shreg  <= '0;
                        bitcnt <= '0;
                    end
                    DATA: begin
                        shreg  <= {data_s, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                    end
                    PARITY:  par <= data_s;
                    default: ;
                endcase
            end else if ((state == IDLE) || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TCW'(1);
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset_i) begin
            code_q   <= 8'h00;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            code_q   <= code_nx;
            strobe_q <= strobe_nx;
            err_q    <= err_nx;
            busy_q   <= (state_nx != IDLE);
        end
    end

    assign bus.code_o    = code_q;
    assign bus.strobe_o  = strobe_q;
    assign bus.err_o     = err_q;
    assign bus.busy_o    = busy_q;
    assign bus.state_dbg = state;

endmodule
